ram_port_arbiter: RTL and testbench

Two-master arbiter that shares the data-side access path of the on-chip RAM (read port 2 plus the byte-masked write port) between the core load/store unit (master 0) and the boot loader/debug DMA (master 1). Each cycle it grants at most one request, drives the RAM address, write-enable and byte-select lines, and returns a registered response with read data one cycle later. Master 0 has fixed priority. A starvation counter guarantees master 1 forward progress. Out-of-range addresses are rejected with an error response. RAM read port 1 (instruction fetch) is not handled by this block.

---
 rtl/ram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the data-side RAM path (read port 2 + byte-masked write port).
// Master 0 has fixed priority; a starvation counter forces a grant to master 1.
module ram_port_arbiter #(
   parameter int RAM_DEPTH_BIT_LEN = 14,
   parameter int STARVE_LIMIT      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_sel_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   output logic        m0_err_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_sel_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic        m1_err_o,
   output logic [31:0] m1_rdata_o,
   output logic [31:0] ram_r_addr_o,
   input  logic [31:0] ram_r_data_i,
   output logic        ram_w_en_o,
   output logic [31:0] ram_w_addr_o,
   output logic [31:0] ram_w_data_o,
   output logic [3:0]  ram_w_sel_o
);

   typedef enum logic {RSP_IDLE, RSP_VALID} rsp_state_t;

   rsp_state_t  rsp0_state, rsp0_next;
   rsp_state_t  rsp1_state, rsp1_next;
   logic [3:0]  starve_cnt;
   logic        starve_hit;
   logic        m0_in_range, m1_in_range;
   logic        sel_we, sel_in_range;
   logic [31:0] sel_addr, sel_wdata;
   logic [3:0]  sel_sel;

   assign m0_in_range = (m0_addr_i[31:RAM_DEPTH_BIT_LEN+2] == '0);
   assign m1_in_range = (m1_addr_i[31:RAM_DEPTH_BIT_LEN+2] == '0);
   assign starve_hit  = (starve_cnt == 4'(STARVE_LIMIT));

   // Master 1 wins only when alone or starved; grants are suppressed while in reset.
   assign m1_gnt_o = rst_n & m1_req_i & (~m0_req_i | starve_hit);
   assign m0_gnt_o = rst_n & m0_req_i & ~m1_gnt_o;

   always_comb begin
      sel_we       = 1'b0;
      sel_in_range = 1'b0;
      sel_addr     = '0;
      sel_wdata    = '0;
      sel_sel      = '0;
      if (m0_gnt_o) begin
         sel_we       = m0_we_i;
         sel_in_range = m0_in_range;
         sel_addr     = m0_addr_i;
         sel_wdata    = m0_wdata_i;
         sel_sel      = m0_sel_i;
      end else if (m1_gnt_o) begin
         sel_we       = m1_we_i;
         sel_in_range = m1_in_range;
         sel_addr     = m1_addr_i;
         sel_wdata    = m1_wdata_i;
         sel_sel      = m1_sel_i;
      end
   end

   assign ram_r_addr_o = sel_addr;
   assign ram_w_addr_o = sel_addr;
   assign ram_w_data_o = sel_wdata;
   assign ram_w_sel_o  = sel_sel;
   assign ram_w_en_o   = (m0_gnt_o | m1_gnt_o) & sel_we & sel_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!m1_req_i || m1_gnt_o) begin
         starve_cnt <= '0;
      end else if (!starve_hit) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   always_comb begin
      rsp0_next = m0_gnt_o ? RSP_VALID : RSP_IDLE;
      rsp1_next = m1_gnt_o ? RSP_VALID : RSP_IDLE;
   end

   // Response payload is captured at the grant edge; writes and errors return zero data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_state <= RSP_IDLE;
         rsp1_state <= RSP_IDLE;
         m0_err_o   <= 1'b0;
         m0_rdata_o <= '0;
         m1_err_o   <= 1'b0;
         m1_rdata_o <= '0;
      end else begin
         rsp0_state <= rsp0_next;
         rsp1_state <= rsp1_next;
         if (m0_gnt_o) begin
            m0_err_o   <= ~m0_in_range;
            m0_rdata_o <= (m0_in_range && !m0_we_i) ? ram_r_data_i : '0;
         end
         if (m1_gnt_o) begin
            m1_err_o   <= ~m1_in_range;
            m1_rdata_o <= (m1_in_range && !m1_we_i) ? ram_r_data_i : '0;
         end
      end
   end

   assign m0_rvalid_o = (rsp0_state == RSP_VALID);
   assign m1_rvalid_o = (rsp1_state == RSP_VALID);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: behavioural RAM plus per-master response scoreboards.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic [31:0] ram_r_addr_o, ram_r_data_i, ram_w_addr_o, ram_w_data_o;
   logic        ram_w_en_o;
   logic [3:0]  ram_w_sel_o;

   logic [31:0] mem [0:255];
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic        exp0_err, exp1_err;
   logic [31:0] exp0_rdata, exp1_rdata;
   int          checks = 0;
   int          errors = 0;

   ram_port_arbiter #(.RAM_DEPTH_BIT_LEN(14), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
      .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
      .ram_r_addr_o(ram_r_addr_o), .ram_r_data_i(ram_r_data_i),
      .ram_w_en_o(ram_w_en_o), .ram_w_addr_o(ram_w_addr_o),
      .ram_w_data_o(ram_w_data_o), .ram_w_sel_o(ram_w_sel_o)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, byte-masked write at the clock edge.
   assign ram_r_data_i = mem[ram_r_addr_o[9:2]];
   always @(posedge clk) begin
      if (ram_w_en_o) begin
         for (int b = 0; b < 4; b++)
            if (ram_w_sel_o[b]) mem[ram_w_addr_o[9:2]][b*8 +: 8] <= ram_w_data_o[b*8 +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        input logic eerr, input logic [31:0] erdata);
      if (m == 0) begin
         m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata; m0_sel_i = sel;
         exp0_err = eerr; exp0_rdata = erdata;
      end else begin
         m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata; m1_sel_i = sel;
         exp1_err = eerr; exp1_rdata = erdata;
      end
   endtask

   // One bus cycle: check grants and write enable, record expectations, then check responses.
   task automatic cycle(input logic eg0, input logic eg1, input logic ewen);
      logic [32:0] r;
      #1;
      chk("m0_gnt", 32'(m0_gnt_o), 32'(eg0));
      chk("m1_gnt", 32'(m1_gnt_o), 32'(eg1));
      chk("ram_w_en", 32'(ram_w_en_o), 32'(ewen));
      if (m0_gnt_o) q0.push_back({exp0_err, exp0_rdata});
      if (m1_gnt_o) q1.push_back({exp1_err, exp1_rdata});
      @(posedge clk);
      @(negedge clk);
      chk("m0_rvalid", 32'(m0_rvalid_o), 32'(q0.size() != 0));
      if (m0_rvalid_o && q0.size() != 0) begin
         r = q0.pop_front();
         chk("m0_err", 32'(m0_err_o), 32'(r[32]));
         chk("m0_rdata", m0_rdata_o, r[31:0]);
      end
      chk("m1_rvalid", 32'(m1_rvalid_o), 32'(q1.size() != 0));
      if (m1_rvalid_o && q1.size() != 0) begin
         r = q1.pop_front();
         chk("m1_err", 32'(m1_err_o), 32'(r[32]));
         chk("m1_rdata", m1_rdata_o, r[31:0]);
      end
      q0.delete();
      q1.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_m0_rvalid", 32'(m0_rvalid_o), 0);
      chk("rst_m1_rvalid", 32'(m1_rvalid_o), 0);
      chk("rst_m0_rdata", m0_rdata_o, 0);
      chk("rst_m1_err", 32'(m1_err_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full-word write then read back on master 0
      drive(0, 1, 1, 32'h10, 32'hAABBCCDD, 4'hF, 0, 0);
      cycle(1, 0, 1);
      drive(0, 1, 0, 32'h10, 0, 4'hF, 0, 32'hAABBCCDD);
      cycle(1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Byte-lane write on master 1
      drive(1, 1, 1, 32'h20, 32'h11223344, 4'hF, 0, 0);
      cycle(0, 1, 1);
      drive(1, 1, 1, 32'h20, 32'h0000EE00, 4'b0010, 0, 0);
      cycle(0, 1, 1);
      drive(1, 1, 0, 32'h20, 0, 4'hF, 0, 32'h1122EE44);
      cycle(0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);

      // Preload words 0..2, then out-of-range accesses
      drive(0, 1, 1, 32'h0, 32'h12345678, 4'hF, 0, 0);
      cycle(1, 0, 1);
      drive(0, 1, 1, 32'h4, 32'h9ABCDEF0, 4'hF, 0, 0);
      cycle(1, 0, 1);
      drive(0, 1, 1, 32'h8, 32'h0F0F0F0F, 4'hF, 0, 0);
      cycle(1, 0, 1);
      drive(0, 1, 1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 1, 0);
      cycle(1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 32'h8000_0000, 0, 4'hF, 1, 0);
      cycle(0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);

      // Back-to-back reads, word 0 must survive the rejected write
      drive(0, 1, 0, 32'h0, 0, 4'hF, 0, 32'h12345678);
      cycle(1, 0, 0);
      drive(0, 1, 0, 32'h4, 0, 4'hF, 0, 32'h9ABCDEF0);
      cycle(1, 0, 0);
      drive(0, 1, 0, 32'h8, 0, 4'hF, 0, 32'h0F0F0F0F);
      cycle(1, 0, 0);

      // Empty byte mask still strobes the RAM and acks, data unchanged
      drive(0, 1, 1, 32'h4, 32'hFFFFFFFF, 4'b0000, 0, 0);
      cycle(1, 0, 1);
      drive(0, 1, 0, 32'h4, 0, 4'hF, 0, 32'h9ABCDEF0);
      cycle(1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0);
      #1 chk("idle_r_addr", ram_r_addr_o, 0);

      // Contention: m1 forced through every fifth cycle
      drive(0, 1, 0, 32'h0, 0, 4'hF, 0, 32'h12345678);
      drive(1, 1, 0, 32'h8, 0, 4'hF, 0, 32'h0F0F0F0F);
      for (int i = 0; i < 10; i++) cycle((i % 5) != 4, (i % 5) == 4, 0);

      // Build up starvation, then reset right after a grant edge
      drive(0, 1, 0, 32'h10, 0, 4'hF, 0, 32'hAABBCCDD);
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      #1 chk("pre_rst_gnt", 32'(m0_gnt_o), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("in_rst_m0_rvalid", 32'(m0_rvalid_o), 0);
      chk("in_rst_m0_rdata", m0_rdata_o, 0);
      chk("in_rst_m0_gnt", 32'(m0_gnt_o), 0);
      chk("in_rst_m1_gnt", 32'(m1_gnt_o), 0);
      chk("in_rst_w_en", 32'(ram_w_en_o), 0);
      @(posedge clk);
      @(negedge clk);
      chk("in_rst_m1_rvalid", 32'(m1_rvalid_o), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cycle(i != 4, i == 4, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
